// File: rtl/split_1000_pkg.sv
// Shared constants for the binary-to-BCD splitter: FSM encoding and digit geometry.
package split_1000_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int MAX_VAL = 999;
  localparam int BCD_W   = 4;
  localparam int NUM_DIG = 3;
  localparam int SCR_W   = NUM_DIG * BCD_W;
endpackage

// File: rtl/split_1000_bcd_add3.sv
// Double-dabble digit correction: bias a BCD digit by 3 when it would overflow on the next shift.
module bcd_add3
  import split_1000_pkg::*;
(
  input  logic [BCD_W-1:0] i_d,
  output logic [BCD_W-1:0] o_d
);
  assign o_d = (i_d >= BCD_W'(5)) ? i_d + BCD_W'(3) : i_d;
endmodule

// File: rtl/split_1000.sv
// Sequential binary-to-3-digit-BCD converter (shift-add-3), one bit per SHIFT cycle.
module split_1000
  import split_1000_pkg::*;
#(
  parameter int IN_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IN_W-1:0]  bin_in,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] hundreds,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             ovf
);
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [IN_W-1:0] LP_MAX = IN_W'(MAX_VAL);

  logic [1:0]                          r_state;
  logic [IN_W-1:0]                     r_val;
  logic                                r_ovf_pend;
  logic [IN_W-1:0]                     r_sh;
  logic [SCR_W-1:0]                    r_bcd;
  logic [CNT_W-1:0]                    r_cnt;

  logic [NUM_DIG-1:0][BCD_W-1:0]       w_adj;
  logic [SCR_W-1:0]                    w_adj_flat;
  logic [SCR_W:0]                      w_shift;
  logic [SCR_W-1:0]                    w_bcd_nxt;
  logic                                w_big;

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    bcd_add3 u_add3 (
      .i_d (r_bcd[g*BCD_W +: BCD_W]),
      .o_d (w_adj[g])
    );
  end

  // The top bit shifted out of the hundreds digit is always 0 for inputs <= 999.
  assign w_adj_flat = w_adj;
  assign w_shift    = {w_adj_flat, r_sh[IN_W-1]};
  assign w_bcd_nxt  = SCR_W'(w_shift);
  assign w_big      = bin_in > LP_MAX;

  assign busy = (r_state == ST_LOAD) || (r_state == ST_SHIFT);
  assign done = (r_state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_val      <= '0;
      r_ovf_pend <= 1'b0;
      r_sh       <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      hundreds   <= '0;
      tens       <= '0;
      ones       <= '0;
      ovf        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_val      <= w_big ? LP_MAX : bin_in;
          r_ovf_pend <= w_big;
          r_state    <= ST_LOAD;
        end
        ST_LOAD: begin
          r_bcd   <= '0;
          r_sh    <= r_val;
          r_cnt   <= '0;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_bcd <= w_bcd_nxt;
          r_sh  <= r_sh << 1;
          r_cnt <= r_cnt + CNT_W'(1);
          // Visible outputs change only here, so scratch values never leak out.
          if (r_cnt == CNT_W'(IN_W - 1)) begin
            hundreds <= w_bcd_nxt[2*BCD_W +: BCD_W];
            tens     <= w_bcd_nxt[BCD_W +: BCD_W];
            ones     <= w_bcd_nxt[0 +: BCD_W];
            ovf      <= r_ovf_pend;
            r_state  <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_split_1000.sv
// Directed bench for split_1000: latency, digit values, clamping, start-while-busy, mid-run reset, full sweep.
module tb_split_1000;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] bin_in = '0;
  logic       busy, done, ovf;
  logic [3:0] hundreds, tens, ones;

  int n_chk = 0;
  int n_fail = 0;

  split_1000 #(.IN_W(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one conversion; optionally keep start high with another value while busy.
  task automatic convert(input string tag, input int v, input int eh, input int et,
                         input int eo, input int eovf, input bit hold, input int hold_v);
    int lat;
    @(negedge clk);
    bin_in = 10'(v);
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (hold) bin_in = 10'(hold_v);
    else      start  = 1'b0;
    check({tag, " busy_load"}, int'(busy), 1);
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (done) begin
        lat   = k;
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    check({tag, " latency"}, lat, 12);
    check({tag, " busy_done"}, int'(busy), 0);
    check({tag, " hundreds"}, int'(hundreds), eh);
    check({tag, " tens"}, int'(tens), et);
    check({tag, " ones"}, int'(ones), eo);
    check({tag, " ovf"}, int'(ovf), eovf);
    @(negedge clk);
    check({tag, " done_1cyc"}, int'(done), 0);
  endtask

  initial begin
    int pulses;
    #1;
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst digits", int'({hundreds, tens, ones}), 0);
    check("rst ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;

    convert("v472", 472, 4, 7, 2, 0, 1'b0, 0);
    convert("v0", 0, 0, 0, 0, 0, 1'b0, 0);
    convert("v999", 999, 9, 9, 9, 0, 1'b0, 0);
    convert("v1023", 1023, 9, 9, 9, 1, 1'b0, 0);
    convert("v5", 5, 0, 0, 5, 0, 1'b0, 0);

    // 456 offered throughout the busy window must be ignored.
    convert("v123hold", 123, 1, 2, 3, 0, 1'b1, 456);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("hold extra_done", pulses, 0);
    check("hold digits_kept", int'({hundreds, tens, ones}), 12'h123);

    convert("v1000", 1000, 9, 9, 9, 1, 1'b0, 0);

    // Reset during the 5th SHIFT cycle.
    @(negedge clk);
    bin_in = 10'd500;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort busy_pre", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort digits", int'({hundreds, tens, ones}), 0);
    check("abort ovf", int'(ovf), 0);
    pulses = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort no_done", pulses, 0);
    convert("v808", 808, 8, 0, 8, 0, 1'b0, 0);

    for (int v = 0; v <= 999; v++)
      convert($sformatf("sweep%0d", v), v, v / 100, (v / 10) % 10, v % 10, 0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
